ov7670_capture: RTL and testbench



---
 rtl/ov7670_capture_pkg.sv | 21 ++
 rtl/ov7670_frame_check.sv | 69 ++++++
 rtl/ov7670_capture.sv | 145 ++++++++++++++
 tb/tb_ov7670_capture.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_capture_pkg.sv
// Shared frame-buffer geometry, capture FSM states and the RGB565 -> RGB444 pixel pack.
package ov7670_capture_pkg;

  localparam int FB_H_PIXELS = 320;
  localparam int FB_V_LINES  = 240;
  localparam int FB_DEPTH    = FB_H_PIXELS * FB_V_LINES;
  localparam int FB_ADDR_W   = 17;
  localparam int FB_PIX_W    = 12;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    CAPTURE    = 1'b1
  } cap_state_e;

  // first = {R4..R0,G5..G3}, second = {G2..G0,B4..B0}; keep the top 4 bits of each channel.
  function automatic logic [FB_PIX_W-1:0] pack_rgb444(input logic [7:0] first,
                                                      input logic [7:0] second);
    return {first[7:4], first[2:0], second[7], second[4:1]};
  endfunction

endpackage

// File: rtl/ov7670_frame_check.sv
// Per-line pixel and per-frame line counters that raise a sticky frame error flag.
// Only instantiated when CAPTURE_CHECK_EN is defined.
module ov7670_frame_check
  import ov7670_capture_pkg::*;
#(
  parameter int H_PIXELS = FB_H_PIXELS,
  parameter int V_LINES  = FB_V_LINES
) (
  input  logic pclk,
  input  logic reset,
  input  logic capturing,
  input  logic href_q,
  input  logic pix_evt,
  input  logic frame_start,
  input  logic frame_end,
  output logic frame_err
);

  localparam int PIX_CW  = $clog2(H_PIXELS + 2);
  localparam int LINE_CW = $clog2(V_LINES + 2);

  logic               href_prev_q, href_prev_d;
  logic [PIX_CW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_CW-1:0] line_cnt_q, line_cnt_d;
  logic               err_q, err_d;
  logic               href_fall;

  assign href_fall = href_prev_q & ~href_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    href_prev_d = href_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    err_d       = err_q;
    if (frame_start) begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      err_d      = 1'b0;
    end else if (capturing) begin
      if (pix_evt && (pix_cnt_q != '1)) pix_cnt_d = pix_cnt_q + 1'b1;
      if (href_fall) begin
        if (pix_cnt_q != PIX_CW'(H_PIXELS)) err_d = 1'b1;
        pix_cnt_d = '0;
        if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
      end
      // Use the updated count so a line ending in the same cycle is included.
      if (frame_end && (line_cnt_d != LINE_CW'(V_LINES))) err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pclk) begin
    if (reset) begin
      href_prev_q <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      href_prev_q <= href_prev_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      err_q       <= err_d;
    end
  end

  assign frame_err = err_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 byte-pair capture into a raster-ordered RGB444 frame buffer.
// Optional CAPTURE_CHECK_EN adds line/pixel count checking (frame_err); otherwise frame_err is 0.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_PIXELS = FB_H_PIXELS,
  parameter int V_LINES  = FB_V_LINES,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_d,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [FB_PIX_W-1:0] dout,
  output logic                frame_done,
  output logic                frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_LINES - 1);

  cap_state_e          state_q, state_d;
  logic                vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
  logic                href_q, href_d;
  logic [7:0]          d_q, d_d;
  logic                phase_q, phase_d;
  logic [7:0]          first_q, first_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                full_q, full_d;
  logic                we_q, we_d;
  logic [FB_PIX_W-1:0] dout_q, dout_d;
  logic                frame_done_q, frame_done_d;

  logic vsync_rise, vsync_fall, capturing, byte_ok, pix_evt;

  assign vsync_rise = vsync_q & ~vsync_prev_q;
  assign vsync_fall = ~vsync_q & vsync_prev_q;
  assign capturing  = (state_q == CAPTURE);
  // A VSYNC edge takes priority: the byte in that cycle is dropped.
  assign byte_ok    = capturing & href_q & ~(vsync_rise | vsync_fall);
  assign pix_evt    = byte_ok & phase_q;

  always_comb begin
    vsync_d      = cam_vsync;
    vsync_prev_d = vsync_q;
    href_d       = cam_href;
    d_d          = cam_d;
    state_d      = state_q;
    phase_d      = 1'b0;
    first_d      = first_q;
    addr_d       = addr_q;
    full_d       = full_q;
    we_d         = 1'b0;
    dout_d       = dout_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      WAIT_FRAME: begin
        addr_d = '0;
        full_d = 1'b0;
        if (vsync_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (vsync_rise) begin
          state_d      = WAIT_FRAME;
          frame_done_d = 1'b1;
          addr_d       = '0;
          full_d       = 1'b0;
        end else begin
          if (href_q) phase_d = ~phase_q;
          if (byte_ok && !phase_q) first_d = d_q;
          if (pix_evt && !full_q) begin
            we_d   = 1'b1;
            dout_d = pack_rgb444(first_q, d_q);
          end
          // Address advances after the write; the final location saturates the frame.
          if (we_q) begin
            if (addr_q == LAST_ADDR) full_d = 1'b1;
            else                     addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= '0;
      phase_q      <= 1'b0;
      first_q      <= '0;
      addr_q       <= '0;
      full_q       <= 1'b0;
      we_q         <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      href_q       <= href_d;
      d_q          <= d_d;
      phase_q      <= phase_d;
      first_q      <= first_d;
      addr_q       <= addr_d;
      full_q       <= full_d;
      we_q         <= we_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign we         = we_q;
  assign addr       = addr_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;

`ifdef CAPTURE_CHECK_EN
  logic frame_start, frame_end;
  assign frame_start = (state_q == WAIT_FRAME) && vsync_fall;
  assign frame_end   = capturing && vsync_rise;

  ov7670_frame_check #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES)
  ) u_frame_check (
    .pclk        (pclk),
    .reset       (reset),
    .capturing   (capturing),
    .href_q      (href_q),
    .pix_evt     (pix_evt),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_err   (frame_err)
  );
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: expected writes are queued as bytes are driven and
// popped by a negedge monitor whenever the DUT strobes we.
module tb_ov7670_capture;
  import ov7670_capture_pkg::*;

  localparam int H     = 320;
  localparam int V     = 8;
  localparam int AW    = 17;
  localparam int DEPTH = H * V;

  logic          pclk = 1'b0;
  logic          reset;
  logic          cam_vsync, cam_href;
  logic [7:0]    cam_d;
  logic          we;
  logic [AW-1:0] addr;
  logic [11:0]   dout;
  logic          frame_done, frame_err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   pix;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  bit  model_cap  = 1'b0;
  bit  model_full = 1'b0;
  int  model_addr = 0;
  logic [AW-1:0] last_addr = '0;
  bit  prev_we = 1'b0;

  always #5 pclk = ~pclk;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .pclk       (pclk),
    .reset      (reset),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_d      (cam_d),
    .we         (we),
    .addr       (addr),
    .dout       (dout),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  function automatic logic [11:0] exp_pix(input logic [7:0] b0, input logic [7:0] b1);
    return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
  endfunction

  always @(negedge pclk) begin
    if (!reset && we) begin
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_spacing: we high on consecutive cycles, addr=%0d", addr);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we: got addr=%0d dout=%h, required no write", addr, dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (addr !== mon_e.addr || dout !== mon_e.pix) begin
          errors++;
          $display("FAIL write: got addr=%0d dout=%h, required addr=%0d dout=%h",
                   addr, dout, mon_e.addr, mon_e.pix);
        end
        last_addr = addr;
      end
    end
    prev_we = we && !reset;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < nbytes; i++) begin
      cam_href = 1'b1;
      cam_d    = (i % 2 == 0) ? b0 : b1;
      if ((i % 2 == 1) && model_cap && !model_full) begin
        exp_q.push_back(wr_t'{addr: AW'(model_addr), pix: exp_pix(b0, b1)});
        if (model_addr == DEPTH - 1) model_full = 1'b1;
        else model_addr++;
      end
      tick();
    end
    cam_href = 1'b0;
    cam_d    = 8'h00;
    tick(4);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic vsync_pulse(input bit exp_err_in);
    bit exp_fd;
    bit exp_err;
    exp_fd = model_cap;
`ifdef CAPTURE_CHECK_EN
    exp_err = exp_err_in;
`else
    exp_err = 1'b0;
`endif
    cam_vsync = 1'b1;
    tick();
    check_val("frame_done_early", {31'd0, frame_done}, 32'd0);
    tick();
    check_val("frame_done_pulse", {31'd0, frame_done}, {31'd0, exp_fd});
    tick();
    check_val("frame_done_width", {31'd0, frame_done}, 32'd0);
    check_val("frame_err_at_end", {31'd0, frame_err}, {31'd0, exp_err});
    check_val("addr_after_vsync", {15'd0, addr}, 32'd0);
    model_cap = 1'b0;
    tick(3);
    cam_vsync = 1'b0;
    tick(4);
    check_val("frame_err_cleared", {31'd0, frame_err}, 32'd0);
    model_cap  = 1'b1;
    model_addr = 0;
    model_full = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    tick(3);
    check_val("rst_we", {31'd0, we}, 32'd0);
    check_val("rst_addr", {15'd0, addr}, 32'd0);
    check_val("rst_dout", {20'd0, dout}, 32'd0);
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_pre_frame();
    send_line(2 * H, 8'hF8, 8'h00);
    check_drained("pre_frame");
    check_val("pre_frame_addr", {15'd0, addr}, 32'd0);
  endtask

  task automatic test_first_line();
    vsync_pulse(1'b0);
    send_line(2 * H, 8'hF8, 8'h00);
    check_drained("first_line");
    check_val("first_line_last_addr", {15'd0, last_addr}, H - 1);
    check_val("first_line_dout", {20'd0, dout}, 32'hF00);
    check_val("first_line_next_addr", {15'd0, addr}, H);
  endtask

  task automatic test_colors();
    send_line(2 * H, 8'h07, 8'hE0);
    check_val("green_dout", {20'd0, dout}, 32'h0F0);
    send_line(2 * H, 8'h00, 8'h1F);
    check_val("blue_dout", {20'd0, dout}, 32'h00F);
    send_line(2 * H, 8'hFF, 8'hFF);
    check_val("white_dout", {20'd0, dout}, 32'hFFF);
    check_drained("colors");
    check_val("colors_last_addr", {15'd0, last_addr}, 4 * H - 1);
    vsync_pulse(1'b1);
  endtask

  task automatic test_full_frame();
    for (int l = 0; l < V; l++) send_line(2 * H, 8'(l * 37 + 5), 8'(l * 91 + 3));
    check_drained("full_frame");
    check_val("full_last_addr", {15'd0, last_addr}, DEPTH - 1);
    check_val("full_addr_hold", {15'd0, addr}, DEPTH - 1);
    send_line(2 * H, 8'hAA, 8'h55);
    check_drained("extra_line");
    check_val("extra_addr_hold", {15'd0, addr}, DEPTH - 1);
    vsync_pulse(1'b1);
  endtask

  task automatic test_odd_line();
    send_line(2 * H + 1, 8'h07, 8'hE0);
    send_line(2 * H, 8'h00, 8'h1F);
    check_drained("odd_line");
    check_val("odd_next_addr", {15'd0, addr}, 2 * H);
    check_val("odd_next_dout", {20'd0, dout}, 32'h00F);
    vsync_pulse(1'b1);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 100; i++) begin
      cam_href = 1'b1;
      cam_d    = (i % 2 == 0) ? 8'h12 : 8'h34;
      if (i % 2 == 1) begin
        exp_q.push_back(wr_t'{addr: AW'(model_addr), pix: exp_pix(8'h12, 8'h34)});
        model_addr++;
      end
      tick();
    end
    cam_href = 1'b0;
    reset    = 1'b1;
    tick();
    check_val("mid_rst_we", {31'd0, we}, 32'd0);
    check_val("mid_rst_addr", {15'd0, addr}, 32'd0);
    check_val("mid_rst_dout", {20'd0, dout}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    model_cap  = 1'b0;
    model_addr = 0;
    tick(2);
    send_line(2 * H, 8'hF8, 8'h00);
    check_drained("post_rst_ignored");
    vsync_pulse(1'b0);
    send_line(2 * H, 8'h07, 8'hE0);
    check_drained("post_rst_resume");
    check_val("post_rst_last_addr", {15'd0, last_addr}, H - 1);
  endtask

`ifdef CAPTURE_CHECK_EN
  task automatic test_frame_check();
    vsync_pulse(1'b1);
    for (int l = 0; l < V - 1; l++) send_line(2 * H, 8'hF8, 8'h00);
    send_line(2 * (H - 2), 8'hF8, 8'h00);
    check_drained("short_line");
    vsync_pulse(1'b1);
    for (int l = 0; l < V; l++) send_line(2 * H, 8'h07, 8'hE0);
    check_drained("clean_frame");
    check_val("clean_frame_err_mid", {31'd0, frame_err}, 32'd0);
    vsync_pulse(1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_pre_frame();
    test_first_line();
    test_colors();
    test_full_frame();
    test_odd_line();
    test_reset_mid_frame();
`ifdef CAPTURE_CHECK_EN
    test_frame_check();
`endif
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
